// File: rtl/sdram_test_gen.sv
// SDRAM self-test pattern generator and read-back checker: write DEPTH words, wait, read back, compare, repeat.
// Optional SDRAM_TEST_ERR_INJECT_EN adds inj_err, which flips bit 0 of word 0 in the pass it is sampled at.
`timescale 1ns/1ps

module sdram_test_gen #(
    parameter int DATA_W     = 16,
    parameter int DEPTH      = 1024,
    parameter int GAP_CYC    = 64,
    parameter int SEED_SHIFT = 12
) (
    input  logic              clk_50m,
    input  logic              rst,
`ifdef SDRAM_TEST_ERR_INJECT_EN
    input  logic              inj_err,
`endif
    input  logic              init_done,
    output logic              wr_en,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_full,
    output logic              rd_start,
    output logic              rd_en,
    input  logic              rd_empty,
    input  logic [DATA_W-1:0] rd_data,
    output logic              error_flag,
    output logic [3:0]        cycle_countor,
    output logic [15:0]       err_cnt
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GAP_W = $clog2(GAP_CYC + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, WRITE, GAP, READ, DRAIN} state_t;

    // Truncating the pass number before the shift gives the same result mod 2^DATA_W.
    function automatic logic [DATA_W-1:0] pattern(input logic [IDX_W-1:0] idx,
                                                  input logic [15:0]      pass);
        return DATA_W'(idx) + (DATA_W'(pass) << SEED_SHIFT);
    endfunction

    logic inj_bit;
`ifdef SDRAM_TEST_ERR_INJECT_EN
    assign inj_bit = inj_err;
`else
    assign inj_bit = 1'b0;
`endif

    state_t             state, state_d;
    logic [IDX_W-1:0]   wr_idx, wr_idx_d;
    logic [IDX_W-1:0]   rd_idx, rd_idx_d;
    logic [GAP_W-1:0]   gap_cnt, gap_d;
    logic [15:0]        pass_num, pass_d;
    logic [3:0]         cnt_d;
    logic               wr_en_d, rd_en_d, rd_start_d;
    logic [DATA_W-1:0]  wr_data_d;
    logic [DATA_W-1:0]  exp_data, exp_d;
    logic               exp_vld, exp_vld_d;
    logic               wr_acc, rd_acc, mismatch;

    assign wr_acc   = wr_en && !wr_full;
    assign rd_acc   = rd_en && !rd_empty;
    // exp_vld marks the cycle in which rd_data belongs to the previously accepted pop.
    assign mismatch = exp_vld && (rd_data != exp_data);

    always_comb begin
        // NOTE: every signal written here gets a default first so no path can infer a latch.
        state_d    = state;
        wr_idx_d   = wr_idx;
        rd_idx_d   = rd_idx;
        gap_d      = gap_cnt;
        pass_d     = pass_num;
        cnt_d      = cycle_countor;
        wr_data_d  = wr_data;
        rd_start_d = 1'b0;
        exp_d      = exp_data;
        exp_vld_d  = 1'b0;

        case (state)
            IDLE: begin
                if (init_done) begin
                    state_d   = WRITE;
                    wr_data_d = pattern('0, pass_num) ^ DATA_W'(inj_bit);
                end
            end
            WRITE: begin
                if (wr_acc) begin
                    if (wr_idx == LAST_IDX) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else begin
                        wr_idx_d  = wr_idx + IDX_W'(1);
                        wr_data_d = pattern(wr_idx + IDX_W'(1), pass_num);
                    end
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_d    = READ;
                    rd_start_d = 1'b1;
                end else begin
                    gap_d = gap_cnt + GAP_W'(1);
                end
            end
            READ: begin
                if (rd_acc) begin
                    exp_d     = pattern(rd_idx, pass_num);
                    exp_vld_d = 1'b1;
                    if (rd_idx == LAST_IDX) begin
                        state_d = DRAIN;
                    end else begin
                        rd_idx_d = rd_idx + IDX_W'(1);
                    end
                end
            end
            DRAIN: begin
                // Last compare lands here; next pass starts without rechecking init_done.
                state_d   = WRITE;
                pass_d    = pass_num + 16'd1;
                cnt_d     = cycle_countor + 4'd1;
                wr_idx_d  = '0;
                rd_idx_d  = '0;
                wr_data_d = pattern('0, pass_num + 16'd1) ^ DATA_W'(inj_bit);
            end
            default: state_d = IDLE;
        endcase

        wr_en_d = (state_d == WRITE);
        rd_en_d = (state_d == READ);
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_d;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            wr_idx        <= '0;
            rd_idx        <= '0;
            gap_cnt       <= '0;
            pass_num      <= '0;
            cycle_countor <= '0;
            wr_en         <= 1'b0;
            wr_data       <= '0;
            rd_en         <= 1'b0;
            rd_start      <= 1'b0;
            exp_data      <= '0;
            exp_vld       <= 1'b0;
        end else begin
            wr_idx        <= wr_idx_d;
            rd_idx        <= rd_idx_d;
            gap_cnt       <= gap_d;
            pass_num      <= pass_d;
            cycle_countor <= cnt_d;
            wr_en         <= wr_en_d;
            wr_data       <= wr_data_d;
            rd_en         <= rd_en_d;
            rd_start      <= rd_start_d;
            exp_data      <= exp_d;
            exp_vld       <= exp_vld_d;
        end
    end

    always_ff @(posedge clk_50m or posedge rst) begin
        if (rst) begin
            error_flag <= 1'b0;
            err_cnt    <= '0;
        end else if (mismatch) begin
            error_flag <= 1'b1;
            if (err_cnt != 16'hFFFF) begin
                err_cnt <= err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_test_gen.sv
// Randomized bench for sdram_test_gen: FIFO/SDRAM model plus a per-cycle protocol and pattern model.
`timescale 1ns/1ps

module tb_sdram_test_gen;

    localparam int DATA_W     = 16;
    localparam int DEPTH      = 16;
    localparam int GAP_CYC    = 5;
    localparam int SEED_SHIFT = 12;
    localparam int LIMIT      = 20000;
`ifdef SDRAM_TEST_ERR_INJECT_EN
    localparam int INJ = 1;
`else
    localparam int INJ = 0;
`endif

    logic              clk_50m = 1'b0;
    logic              rst = 1'b0;
    logic              init_done = 1'b0;
    logic              wr_full = 1'b0;
    logic              rd_empty = 1'b1;
    logic              inj_err = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wr_en, rd_en, rd_start, error_flag;
    logic [DATA_W-1:0] wr_data;
    logic [3:0]        cycle_countor;
    logic [15:0]       err_cnt;

    sdram_test_gen #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .GAP_CYC(GAP_CYC), .SEED_SHIFT(SEED_SHIFT)
    ) dut (
        .clk_50m(clk_50m),
        .rst(rst),
`ifdef SDRAM_TEST_ERR_INJECT_EN
        .inj_err(inj_err),
`endif
        .init_done(init_done),
        .wr_en(wr_en),
        .wr_data(wr_data),
        .wr_full(wr_full),
        .rd_start(rd_start),
        .rd_en(rd_en),
        .rd_empty(rd_empty),
        .rd_data(rd_data),
        .error_flag(error_flag),
        .cycle_countor(cycle_countor),
        .err_cnt(err_cnt)
    );

    initial forever #5 clk_50m = ~clk_50m;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) n_pass++;
        else $display("FAIL %s: actual=0x%0h expected=0x%0h t=%0t", name, actual, expected, $time);
    endtask

    function automatic logic [15:0] pat(input int idx, input int p);
        return 16'((idx + (p << SEED_SHIFT)) & 32'hFFFF);
    endfunction

    // Reference model state
    bit          mon_en;
    int          run_id;
    bit          started, wr_window, open_is_new, rd_started, inj_pass;
    int          wr_open_in, p_m, wcnt, rcnt, since_last, err_m, countor_m;
    bit          s1, s2, pop_pending, stall_prev, stall_done;
    int          stall_left;
    logic [15:0] next_word, stall_data;
    logic [15:0] mem[$];
    logic [15:0] rdq[$];
    logic [15:0] wr_log[4][DEPTH];
    int          countor_log[$];

    task automatic model_reset();
        started = 0; wr_window = 0; open_is_new = 0; rd_started = 0; inj_pass = 0;
        wr_open_in = 0; p_m = 0; wcnt = 0; rcnt = 0; since_last = 0; err_m = 0; countor_m = 0;
        s1 = 0; s2 = 0; pop_pending = 0; stall_prev = 0; stall_left = 0;
        mem.delete(); rdq.delete();
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < DEPTH; b++) wr_log[a][b] = 16'hDEAD;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, wr_en, 0);
        check({tag, "_wr_data"}, wr_data, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_rd_start"}, rd_start, 0);
        check({tag, "_error_flag"}, error_flag, 0);
        check({tag, "_cycle_countor"}, cycle_countor, 0);
        check({tag, "_err_cnt"}, err_cnt, 0);
    endtask

    // Compare process: checks outputs each cycle and advances the model on accepted transfers.
    initial begin
        bit          exp_rd_start;
        logic [15:0] exp_w;
        forever begin
            @(negedge clk_50m);
            if (mon_en) begin
                err_m += int'(s2); s2 = s1; s1 = 0;
                if (wr_open_in > 0) begin
                    wr_open_in--;
                    if (wr_open_in == 0) begin
                        if (open_is_new) begin
                            p_m++;
                            countor_m = (countor_m + 1) % 16;
                            if (run_id == 0) countor_log.push_back(int'(cycle_countor));
                        end
                        wr_window = 1; wcnt = 0; rcnt = 0; rd_started = 0; since_last = 0;
                        mem.delete();
                        inj_pass = (INJ != 0) && inj_err;
                    end
                end
                if (wcnt == DEPTH && !rd_started) since_last++;
                exp_rd_start = (wcnt == DEPTH) && !rd_started && (since_last == GAP_CYC + 1);
                if (exp_rd_start) begin
                    rd_started = 1;
                    rdq = mem;
                    if (run_id == 0 && p_m == 0) rdq[5] = 16'hFFFF;
                end
                check("wr_en", wr_en, wr_window && (wcnt < DEPTH));
                check("rd_en", rd_en, rd_started && (rcnt < DEPTH));
                check("rd_start", rd_start, exp_rd_start);
                check("wr_rd_excl", wr_en & rd_en, 0);
                check("err_cnt", err_cnt, (err_m > 65535) ? 65535 : err_m);
                check("error_flag", error_flag, err_m != 0);
                check("cycle_countor", cycle_countor, countor_m);
                if (stall_prev) check("wr_data_stall", wr_data, stall_data);
                stall_prev = wr_en && wr_full;
                stall_data = wr_data;
                if (wr_en && !wr_full && wcnt < DEPTH) begin
                    exp_w = pat(wcnt, p_m);
                    if (wcnt == 0 && inj_pass) exp_w = exp_w ^ 16'h0001;
                    check("wr_data", wr_data, exp_w);
                    if (p_m < 4) wr_log[p_m][wcnt] = wr_data;
                    mem.push_back(wr_data);
                    wcnt++;
                    if (wcnt == DEPTH) since_last = 0;
                end
                pop_pending = 0;
                if (rd_en && !rd_empty && rdq.size() > 0) begin
                    next_word   = rdq.pop_front();
                    pop_pending = 1;
                    s1 = (next_word != pat(rcnt, p_m));
                    rcnt++;
                    if (rcnt == DEPTH) begin
                        wr_open_in  = 2;
                        open_is_new = 1;
                    end
                end
                if (!started && init_done) begin
                    started     = 1;
                    wr_open_in  = 1;
                    open_is_new = 0;
                end
            end
        end
    end

    // FIFO / SDRAM side: drives inputs just after each rising edge.
    initial begin
        forever begin
            @(posedge clk_50m);
            #1;
            rd_data = pop_pending ? next_word : 16'($urandom);
            if (mon_en && run_id == 0 && p_m == 1 && rcnt == 8 && !stall_done) begin
                stall_left = 20;
                stall_done = 1;
            end
            wr_full  = mon_en && (run_id != 0 || p_m >= 1) && ($urandom_range(0, 2) == 0);
            rd_empty = (rdq.size() == 0) || (stall_left > 0) || (p_m >= 2 && $urandom_range(0, 3) == 0);
            if (stall_left > 0) stall_left--;
            inj_err  = (INJ != 0) && (run_id == 0) && ((p_m + ((rcnt == DEPTH) ? 1 : 0)) == 3);
            if (mon_en && started) init_done = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int guard;
        model_reset();
        stall_done = 0;
        run_id = 0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk_50m);
        #3;
        check_all_zero("reset");
        rst = 1'b0;
        mon_en = 1;
        repeat (5) @(posedge clk_50m);
        #3;
        init_done = 1'b1;

        // Run A: corrupted word in pass 0, random back-pressure, 17 passes.
        guard = 0;
        while (countor_log.size() < 17 && guard < LIMIT) begin
            @(posedge clk_50m);
            guard++;
        end
        #3;
        check("runA_done_in_time", guard < LIMIT, 1);
        for (int i = 0; i < 17; i++) begin
            if (countor_log.size() > i) check($sformatf("countor_seq_%0d", i), countor_log[i], (i + 1) % 16);
            else check($sformatf("countor_seq_%0d_missing", i), 0, 1);
        end
        check("p0_w0", wr_log[0][0], 16'h0000);
        check("p0_w15", wr_log[0][15], 16'h000F);
        check("p1_w0", wr_log[1][0], 16'h1000);
        check("p1_w15", wr_log[1][15], 16'h100F);
        check("p2_w7", wr_log[2][7], 16'h2007);
        check("p3_w0", wr_log[3][0], (INJ != 0) ? 16'h3001 : 16'h3000);
        check("runA_err_cnt", err_cnt, 1 + INJ);
        check("runA_error_flag", error_flag, 1);

        // Run B: async reset mid-activity, restart, reset during READ of pass 2.
        mon_en = 0;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst1");
        model_reset();
        run_id = 1;
        init_done = 1'b0;
        repeat (2) @(posedge clk_50m);
        #3;
        rst = 1'b0;
        mon_en = 1;
        repeat (3) @(posedge clk_50m);
        #3;
        init_done = 1'b1;
        guard = 0;
        while (!(p_m == 2 && rd_started && rcnt >= 5) && guard < LIMIT) begin
            @(posedge clk_50m);
            guard++;
        end
        #3;
        check("runB_read2_in_time", guard < LIMIT, 1);
        check("pre_rst_countor", cycle_countor, 2);
        mon_en = 0;
        rst = 1'b1;
        #1;
        check_all_zero("async_rst_read2");
        model_reset();
        run_id = 2;
        init_done = 1'b0;
        repeat (2) @(posedge clk_50m);
        #3;
        rst = 1'b0;
        mon_en = 1;
        repeat (4) @(posedge clk_50m);
        #3;
        init_done = 1'b1;
        guard = 0;
        while (p_m < 1 && guard < LIMIT) begin
            @(posedge clk_50m);
            guard++;
        end
        repeat (2) @(posedge clk_50m);
        #3;
        check("runC_pass_in_time", guard < LIMIT, 1);
        check("restart_w0", wr_log[0][0], 16'h0000);
        check("restart_w15", wr_log[0][15], 16'h000F);
        check("restart_countor", cycle_countor, 1);
        check("restart_err_cnt", err_cnt, 0);
        check("restart_error_flag", error_flag, 0);

        mon_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
